// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg : shared types and constants for the i2c link controller
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package i2c_pkg;

    localparam int unsigned C_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RXA    = 2'd1,
        ST_TXA    = 2'd2,
        ST_REPLAY = 2'd3
    } state_e;

    localparam logic [6:0] C_DEFAULT_ADDR = 7'h00;

endpackage

`default_nettype wire

// File: rtl/i2c_word_fifo.sv
// ----------------------------------------------------------------------------
// i2c_word_fifo : 32-bit synchronous FIFO with occupancy output and clear
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_word_fifo
    import i2c_pkg::*;
#(
    parameter int unsigned AW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_push,
    input  logic [C_DW-1:0] i_data,
    input  logic            i_pop,
    output logic [C_DW-1:0] o_data,
    output logic [AW:0]     o_level,
    output logic            o_full,
    output logic            o_empty
);

    localparam logic [AW:0] C_FULL = {1'b1, {AW{1'b0}}};

    logic [C_DW-1:0] r_mem [C_FULL];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_level;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_level == C_FULL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rp];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else if (i_clr) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_link_ctrl.sv
// ----------------------------------------------------------------------------
// i2c_link_ctrl : word-level glue between i2c slave PHY and two TX requesters,
//                 RX buffering, read-error replay and address sequencing
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_link_ctrl
    import i2c_pkg::*;
#(
    parameter int unsigned TX_AW = 2,
    parameter int unsigned RX_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [31:0]       req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [31:0]       req1_data,
    output logic              req1_ready,
    output logic              rx_valid,
    output logic [31:0]       rx_data,
    input  logic              rx_ready,
    input  logic              tx_flush,
    input  logic [6:0]        cfg_addr,
    input  logic              cfg_wr,
    output logic [6:0]        phy_addr,
    output logic              phy_full,
    input  logic              phy_push,
    input  logic [31:0]       phy_dout,
    output logic              phy_empty,
    input  logic              phy_pop,
    output logic [31:0]       phy_din,
    input  logic              phy_wstop,
    input  logic              phy_rstop,
    input  logic              phy_rerr,
    output logic              irq_rx,
    output logic              irq_tx,
    output logic [7:0]        err_cnt,
    output logic [TX_AW:0]    tx_level,
    output logic [RX_AW:0]    rx_level,
    output logic              ovf,
    output logic              udf
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_rr;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic [31:0] w_tx_head;
    logic        w_tx_deq;
    logic        w_pop_replay;
    logic        w_pop_ok;
    logic        w_udf_evt;
    logic        w_rerr_evt;
    logic        w_irq_rx;
    logic        w_irq_tx;
    logic        w_enter_idle;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic [31:0] r_shadow;
    logic        r_shadow_vld;
    logic        r_replay;
    logic        r_irq_rx;
    logic        r_irq_tx;
    logic [7:0]  r_err_cnt;
    logic        r_ovf;
    logic        r_udf;
    logic [6:0]  r_addr;
    logic [6:0]  r_pend_addr;
    logic        r_pend;

    // Round-robin: r_rr names the requester holding priority this cycle.
    assign w_gnt0 = req0_valid & ~w_tx_full & ~tx_flush & (~r_rr | ~req1_valid);
    assign w_gnt1 = req1_valid & ~w_tx_full & ~tx_flush & ( r_rr | ~req0_valid);

    assign w_pop_replay = phy_pop & r_replay;
    assign w_tx_deq     = phy_pop & ~r_replay & ~w_tx_empty;
    assign w_pop_ok     = w_pop_replay | w_tx_deq;
    assign w_udf_evt    = phy_pop & ~r_replay & w_tx_empty;

    i2c_word_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (tx_flush),
        .i_push  (w_gnt0 | w_gnt1),
        .i_data  (w_gnt1 ? req1_data : req0_data),
        .i_pop   (w_tx_deq),
        .o_data  (w_tx_head),
        .o_level (tx_level),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    i2c_word_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (1'b0),
        .i_push  (phy_push),
        .i_data  (phy_dout),
        .i_pop   (rx_ready),
        .o_data  (rx_data),
        .o_level (rx_level),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (phy_rerr & w_pop_ok) w_state_nxt = ST_REPLAY;
                else if (w_pop_ok)       w_state_nxt = ST_TXA;
                else if (phy_push)       w_state_nxt = ST_RXA;
            end
            ST_RXA: begin
                if (phy_wstop) w_state_nxt = ST_IDLE;
            end
            ST_TXA: begin
                if (phy_rerr)       w_state_nxt = ST_REPLAY;
                else if (phy_rstop) w_state_nxt = ST_IDLE;
            end
            ST_REPLAY: begin
                if (phy_rerr & w_pop_ok) w_state_nxt = ST_REPLAY;
                else if (w_pop_ok)       w_state_nxt = ST_TXA;
                else if (phy_rstop)      w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rerr_evt   = phy_rerr & ((r_state == ST_TXA) |
                       (((r_state == ST_IDLE) | (r_state == ST_REPLAY)) & w_pop_ok));
        w_irq_rx     = (r_state == ST_RXA) & phy_wstop;
        w_irq_tx     = (r_state == ST_TXA) & phy_rstop & ~phy_rerr;
        w_enter_idle = (r_state != ST_IDLE) & (w_state_nxt == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_shadow_vld <= 1'b0;
            r_replay     <= 1'b0;
            r_rr         <= 1'b0;
            r_irq_rx     <= 1'b0;
            r_irq_tx     <= 1'b0;
            r_err_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
            r_addr       <= C_DEFAULT_ADDR;
            r_pend_addr  <= C_DEFAULT_ADDR;
            r_pend       <= 1'b0;
        end else begin
            if (w_gnt0)      r_rr <= 1'b1;
            else if (w_gnt1) r_rr <= 1'b0;

            if (w_tx_deq) r_shadow <= w_tx_head;

            // Flush wins over everything touching the replay path.
            if (tx_flush) begin
                r_shadow_vld <= 1'b0;
                r_replay     <= 1'b0;
            end else begin
                if (w_tx_deq)      r_shadow_vld <= 1'b1;
                else if (w_irq_tx) r_shadow_vld <= 1'b0;
                if (w_rerr_evt)        r_replay <= r_shadow_vld | w_tx_deq;
                else if (w_pop_replay) r_replay <= 1'b0;
            end

            r_irq_rx <= w_irq_rx;
            r_irq_tx <= w_irq_tx;

            if (w_rerr_evt && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (phy_push & w_rx_full) r_ovf <= 1'b1;
            if (w_udf_evt)            r_udf <= 1'b1;

            // Address changes only land while the link is idle.
            if ((cfg_wr && r_state == ST_IDLE) || (w_enter_idle && (cfg_wr || r_pend))) begin
                r_addr <= cfg_wr ? cfg_addr : r_pend_addr;
                r_pend <= 1'b0;
            end else if (cfg_wr) begin
                r_pend_addr <= cfg_addr;
                r_pend      <= 1'b1;
            end
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rx_valid   = ~w_rx_empty;
    assign phy_full   = w_rx_full;
    assign phy_din    = r_replay ? r_shadow : w_tx_head;
    assign phy_empty  = w_tx_empty & ~r_replay;
    assign phy_addr   = r_addr;
    assign irq_rx     = r_irq_rx;
    assign irq_tx     = r_irq_tx;
    assign err_cnt    = r_err_cnt;
    assign ovf        = r_ovf;
    assign udf        = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_i2c_link_ctrl.sv
// ----------------------------------------------------------------------------
// tb_i2c_link_ctrl : directed self-checking bench for i2c_link_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_i2c_link_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic        rx_valid, rx_ready;
    logic [31:0] rx_data;
    logic        tx_flush, cfg_wr;
    logic [6:0]  cfg_addr, phy_addr;
    logic        phy_full, phy_push, phy_empty, phy_pop;
    logic [31:0] phy_dout, phy_din;
    logic        phy_wstop, phy_rstop, phy_rerr;
    logic        irq_rx, irq_tx, ovf, udf;
    logic [7:0]  err_cnt;
    logic [2:0]  tx_level, rx_level;

    int n_assert;
    int n_fail;
    logic [31:0] sb_tx[$];
    logic [31:0] sb_rx[$];
    logic [31:0] w_exp;

    i2c_link_ctrl #(.TX_AW(2), .RX_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_flush(tx_flush), .cfg_addr(cfg_addr), .cfg_wr(cfg_wr),
        .phy_addr(phy_addr), .phy_full(phy_full), .phy_push(phy_push),
        .phy_dout(phy_dout), .phy_empty(phy_empty), .phy_pop(phy_pop),
        .phy_din(phy_din), .phy_wstop(phy_wstop), .phy_rstop(phy_rstop),
        .phy_rerr(phy_rerr), .irq_rx(irq_rx), .irq_tx(irq_tx),
        .err_cnt(err_cnt), .tx_level(tx_level), .rx_level(rx_level),
        .ovf(ovf), .udf(udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_sb_tx(input string tag);
        if (sb_tx.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, phy_din);
        end else begin
            w_exp = sb_tx.pop_front();
            chk(tag, phy_din, w_exp);
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0;
        rst_n = 1'b0;
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        rx_ready = 0; tx_flush = 0; cfg_addr = '0; cfg_wr = 0;
        phy_push = 0; phy_dout = '0; phy_pop = 0;
        phy_wstop = 0; phy_rstop = 0; phy_rerr = 0;

        repeat (3) @(negedge clk);
        chk("rst_phy_empty", {31'd0, phy_empty}, 32'd1);
        chk("rst_tx_level", {29'd0, tx_level}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_phy_addr", {25'd0, phy_addr}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_flags", {28'd0, ovf, udf, irq_rx, irq_tx}, 32'd0);
        rst_n = 1'b1;

        // Both requesters contend for six cycles; FIFO fills at four words.
        begin
            logic [1:0] exp_gnt [6];
            exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                req0_valid = 1; req1_valid = 1;
                req0_data = 32'h0000_0100 + i;
                req1_data = 32'h0000_0200 + i;
                #1;
                chk($sformatf("arb_gnt%0d", i), {30'd0, req1_ready, req0_ready}, {30'd0, exp_gnt[i]});
                if (exp_gnt[i][0]) sb_tx.push_back(req0_data);
                if (exp_gnt[i][1]) sb_tx.push_back(req1_data);
            end
        end
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        #1 chk("arb_level_full", {29'd0, tx_level}, 32'd4);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            phy_pop = 1;
            #1 chk_sb_tx($sformatf("tx_word%0d", i));
        end
        @(negedge clk);
        phy_pop = 0; phy_rstop = 1;
        @(posedge clk); #1;
        chk("irq_tx_pulse", {31'd0, irq_tx}, 32'd1);
        chk("tx_drained_empty", {31'd0, phy_empty}, 32'd1);
        @(negedge clk);
        phy_rstop = 0;
        @(posedge clk); #1;
        chk("irq_tx_one_cycle", {31'd0, irq_tx}, 32'd0);

        // Read error replays the shadowed word.
        @(negedge clk);
        req0_valid = 1; req0_data = 32'hA5A5_0001;
        sb_tx.push_back(32'hA5A5_0001);
        #1 chk("replay_enq_ready", {31'd0, req0_ready}, 32'd1);
        @(negedge clk);
        req0_valid = 0; phy_pop = 1;
        #1 chk_sb_tx("replay_pop1");
        @(negedge clk);
        phy_pop = 0; phy_rerr = 1;
        sb_tx.push_back(32'hA5A5_0001);
        @(negedge clk);
        phy_rerr = 0;
        #1;
        chk("replay_err_cnt", {24'd0, err_cnt}, 32'd1);
        chk("replay_not_empty", {31'd0, phy_empty}, 32'd0);
        @(negedge clk);
        phy_pop = 1;
        #1 chk_sb_tx("replay_pop2");
        @(negedge clk);
        phy_pop = 0;
        #1;
        chk("replay_tx_level", {29'd0, tx_level}, 32'd0);
        chk("replay_done_empty", {31'd0, phy_empty}, 32'd1);
        phy_rstop = 1;
        @(negedge clk);
        phy_rstop = 0;

        // RX FIFO fill, overflow and drain.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            phy_push = 1; phy_dout = 32'hC0DE_0000 + i;
            sb_rx.push_back(phy_dout);
        end
        @(negedge clk);
        #1 chk("rx_full", {31'd0, phy_full}, 32'd1);
        phy_dout = 32'hDEAD_BEEF;
        @(negedge clk);
        phy_push = 0;
        #1;
        chk("rx_ovf", {31'd0, ovf}, 32'd1);
        chk("rx_level_full", {29'd0, rx_level}, 32'd4);
        phy_wstop = 1;
        @(posedge clk); #1;
        chk("irq_rx_pulse", {31'd0, irq_rx}, 32'd1);
        @(negedge clk);
        phy_wstop = 0; rx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (sb_rx.size() != 0) begin
                w_exp = sb_rx.pop_front();
                chk($sformatf("rx_word%0d", i), rx_data, w_exp);
            end
            @(negedge clk);
        end
        rx_ready = 0;
        #1 chk("rx_drained", {31'd0, rx_valid}, 32'd0);

        // Address write during a read transaction is deferred.
        @(negedge clk);
        req0_valid = 1; req0_data = 32'h0000_1234;
        sb_tx.push_back(req0_data);
        @(negedge clk);
        req0_valid = 0; phy_pop = 1;
        #1 chk_sb_tx("cfg_tx_word");
        @(negedge clk);
        phy_pop = 0; cfg_wr = 1; cfg_addr = 7'h2A;
        @(negedge clk);
        cfg_wr = 0;
        @(negedge clk);
        #1 chk("cfg_held", {25'd0, phy_addr}, 32'd0);
        phy_rstop = 1;
        @(posedge clk); #1;
        chk("cfg_applied", {25'd0, phy_addr}, 32'h2A);
        chk("cfg_irq_tx", {31'd0, irq_tx}, 32'd1);
        @(negedge clk);
        phy_rstop = 0;
        @(posedge clk); #1;
        chk("cfg_irq_tx_once", {31'd0, irq_tx}, 32'd0);

        // Pop with empty TX: underflow, no state change.
        chk("udf_before", {31'd0, udf}, 32'd0);
        @(negedge clk);
        phy_pop = 1;
        @(negedge clk);
        phy_pop = 0;
        #1;
        chk("udf_set", {31'd0, udf}, 32'd1);
        chk("udf_level", {29'd0, tx_level}, 32'd0);
        cfg_wr = 1; cfg_addr = 7'h15;
        @(posedge clk); #1;
        chk("udf_still_idle", {25'd0, phy_addr}, 32'h15);
        @(negedge clk);
        cfg_wr = 0;

        // Flush dominates a same-cycle grant.
        req0_valid = 1; req0_data = 32'h0000_0077;
        @(negedge clk);
        tx_flush = 1;
        #1 chk("flush_ready_low", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        tx_flush = 0; req0_valid = 0;
        #1 chk("flush_level", {29'd0, tx_level}, 32'd0);

        // Reset in the middle of a write transaction.
        @(negedge clk);
        phy_push = 1; phy_dout = 32'h0000_0055;
        @(negedge clk);
        phy_push = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_levels", {26'd0, rx_level, tx_level}, 32'd0);
        chk("arst_phy_empty", {31'd0, phy_empty}, 32'd1);
        chk("arst_flags", {30'd0, ovf, udf}, 32'd0);
        @(negedge clk);
        rst_n = 1; phy_wstop = 1;
        @(posedge clk); #1;
        chk("arst_no_irq_rx", {31'd0, irq_rx}, 32'd0);
        @(negedge clk);
        phy_wstop = 0;
        @(posedge clk); #1;
        chk("arst_no_irq_rx2", {31'd0, irq_rx}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
